// File: rtl/mem_access_unit.sv
// Data-memory stage: byte/word loads and stores with wait states,
// alignment fault pulse and branch-select decode.
module mem_access_unit #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic              byte_en,
    input  logic              sign_ext,
    input  logic              Branch,
    input  logic              Zero,
    input  logic              branch_ne,
    output logic [DATA_W-1:0] read_data_mem,
    output logic              PCSrc_out,
    output logic              stall,
    output logic              align_fault
);

    localparam int BS = $clog2(DATA_W / 8);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = BS + 3;
    localparam logic [DATA_W-1:0] BYTE_MASK = DATA_W'(8'hFF);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic [AW-1:0]     r_idx;
    logic [BS-1:0]     r_lane;
    logic [DATA_W-1:0] r_wdata;
    logic              r_byte;
    logic              r_sext;
    logic              r_store;
    logic [DATA_W-1:0] r_rdata;
    logic              r_fault;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_req;
    logic              w_mis;
    logic [AW-1:0]     w_idx;
    logic [BS-1:0]     w_lane;
    logic              w_commit;
    logic [SW-1:0]     w_shift;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_rd_shift;
    logic [7:0]        w_lane_byte;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_wval;
    logic [DATA_W-1:0] w_load_val;
    logic [DATA_W-1:0] w_store_word;
    logic              w_unused;

    // Request decode; upper address bits wrap, so they only feed w_unused
    assign w_req    = MemRead | MemWrite;
    assign w_idx    = address[AW+BS-1:BS];
    assign w_lane   = address[BS-1:0];
    assign w_mis    = !byte_en && (w_lane != '0);
    assign w_unused = ^address;

    // Datapath on the captured request
    assign w_commit     = (r_state == S_BUSY) && (r_cnt == 3'd0);
    assign w_shift      = {r_lane, 3'b000};
    assign w_word       = r_mem[r_idx];
    assign w_rd_shift   = w_word >> w_shift;
    assign w_lane_byte  = w_rd_shift[7:0];
    assign w_mask       = BYTE_MASK << w_shift;
    assign w_wval       = DATA_W'(r_wdata[7:0]) << w_shift;
    assign w_load_val   = !r_byte ? w_word :
                          r_sext  ? {{(DATA_W-8){w_lane_byte[7]}}, w_lane_byte} :
                                    {{(DATA_W-8){1'b0}}, w_lane_byte};
    assign w_store_word = r_byte ? ((w_word & ~w_mask) | (w_wval & w_mask))
                                 : r_wdata;

    assign stall         = ((r_state == S_IDLE) && w_req && !w_mis)
                         || (r_state == S_BUSY);
    assign PCSrc_out     = Branch & (Zero ^ branch_ne);
    assign read_data_mem = r_rdata;
    assign align_fault   = r_fault;

    // Access sequencer: capture, count wait states, commit, one DONE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_idx   <= '0;
            r_lane  <= '0;
            r_wdata <= '0;
            r_byte  <= 1'b0;
            r_sext  <= 1'b0;
            r_store <= 1'b0;
            r_rdata <= '0;
            r_fault <= 1'b0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_mis) begin
                            r_fault <= 1'b1;
                        end else begin
                            r_idx   <= w_idx;
                            r_lane  <= w_lane;
                            r_wdata <= write_data;
                            r_byte  <= byte_en;
                            r_sext  <= sign_ext;
                            r_store <= MemWrite;
                            r_cnt   <= 3'(WAIT_STATES);
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        r_state <= S_DONE;
                        if (!r_store) r_rdata <= w_load_val;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Store commit; the array itself is never reset
    always_ff @(posedge clk) begin
        if (w_commit && r_store) r_mem[r_idx] <= w_store_word;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-addressed reference model,
// two instances (2 and 0 wait states).
module tb_mem_access_unit;

    typedef struct {
        int          dut;
        bit          fault;
        logic [15:0] rd;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        be, se, br, zf, bne;
    logic        mr0, mw0, mr1, mw1;
    logic [15:0] rd0, rd1;
    logic        pc0, pc1, stall0, stall1, af0, af1;

    exp_t        exp_q[$];
    logic [7:0]  mem_b [2][512];
    logic [15:0] last_rd [2];
    int          run [2];
    bit          abort_run;
    int          n_checks;
    int          n_err;

    mem_access_unit #(.DATA_W(16), .DEPTH(256), .WAIT_STATES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .address(addr), .write_data(wdata),
        .MemWrite(mw0), .MemRead(mr0), .byte_en(be), .sign_ext(se),
        .Branch(br), .Zero(zf), .branch_ne(bne),
        .read_data_mem(rd0), .PCSrc_out(pc0), .stall(stall0),
        .align_fault(af0)
    );

    mem_access_unit #(.DATA_W(16), .DEPTH(256), .WAIT_STATES(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .address(addr), .write_data(wdata),
        .MemWrite(mw1), .MemRead(mr1), .byte_en(be), .sign_ext(se),
        .Branch(br), .Zero(zf), .branch_ne(bne),
        .read_data_mem(rd1), .PCSrc_out(pc1), .stall(stall1),
        .align_fault(af1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per completed access or fault pulse
    always @(negedge clk) begin
        logic        st, f;
        logic [15:0] r;
        exp_t        e;
        for (int d = 0; d < 2; d++) begin
            st = (d == 0) ? stall0 : stall1;
            f  = (d == 0) ? af0 : af1;
            r  = (d == 0) ? rd0 : rd1;
            if (f === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected fault", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("fault dut", d, e.dut);
                    chk("fault expected", 1, 32'(e.fault));
                    chk("fault rdata held", r, e.rd);
                    chk("fault stall low", run[d], 0);
                end
            end
            if (st === 1'b1) begin
                run[d]++;
            end else if (run[d] != 0) begin
                if (abort_run) begin
                    abort_run = 1'b0;
                end else if (exp_q.size() == 0) begin
                    chk("unexpected access end", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("access dut", d, e.dut);
                    chk("access not fault", 0, 32'(e.fault));
                    chk("access stall cycles", run[d], (d == 0) ? 4 : 2);
                    chk("access rdata", r, e.rd);
                end
                run[d] = 0;
            end
        end
    end

    task automatic clear_req();
        mr0 = 1'b0; mw0 = 1'b0; mr1 = 1'b0; mw1 = 1'b0;
    endtask

    // op: 0 load, 1 store, 2 load+store (acts as store)
    task automatic do_access(int d, int op, bit b, bit s,
                             logic [15:0] a, logic [15:0] wd);
        exp_t       e;
        int         ba;
        int         n;
        bit         mis;
        bit         st;
        logic [7:0] v;
        @(posedge clk); #1;
        addr = a; wdata = wd; be = b; se = s;
        st = (op != 0);
        if (d == 0) begin mr0 = (op != 1); mw0 = st; end
        else        begin mr1 = (op != 1); mw1 = st; end
        ba  = int'(a) % 512;
        mis = !b && (ba % 2 != 0);
        if (!mis) begin
            if (st) begin
                mem_b[d][ba] = wd[7:0];
                if (!b) mem_b[d][ba+1] = wd[15:8];
            end else if (b) begin
                v = mem_b[d][ba];
                last_rd[d] = s ? {{8{v[7]}}, v} : {8'h00, v};
            end else begin
                last_rd[d] = {mem_b[d][ba+1], mem_b[d][ba]};
            end
        end
        e.dut = d; e.fault = mis; e.rd = last_rd[d];
        exp_q.push_back(e);
        if (mis) begin
            @(posedge clk); #1;
        end else begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (((d == 0) ? stall0 : stall1) !== 1'b0 && n < 20);
            if (n >= 20) chk("access timeout", 1, 0);
        end
        clear_req();
    endtask

    task automatic check_branch();
        for (int i = 0; i < 8; i++) begin
            br = i[0]; zf = i[1]; bne = i[2];
            #1;
            chk("PCSrc dut0", pc0, (br && (bne ? !zf : zf)) ? 1 : 0);
            chk("PCSrc dut1", pc1, (br && (bne ? !zf : zf)) ? 1 : 0);
        end
    endtask

    initial begin
        n_checks = 0; n_err = 0; abort_run = 1'b0;
        run[0] = 0; run[1] = 0;
        last_rd[0] = '0; last_rd[1] = '0;
        rst_n = 1'b0; addr = '0; wdata = '0;
        be = 0; se = 0; br = 0; zf = 0; bne = 0;
        clear_req();
        repeat (2) @(posedge clk);
        #1;
        chk("reset rdata0", rd0, 0);
        chk("reset fault0", af0, 0);
        chk("reset stall0", stall0, 0);
        chk("reset rdata1", rd1, 0);
        rst_n = 1'b1;

        check_branch();

        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 64; a += 2)
                do_access(d, 1, 0, 0, 16'(a), 16'($urandom));

        do_access(0, 1, 0, 0, 16'h0010, 16'hBEEF);
        do_access(0, 0, 0, 0, 16'h0010, 16'h0000);
        do_access(0, 1, 1, 0, 16'h0011, 16'h0012);
        do_access(0, 0, 1, 0, 16'h0011, 16'h0000);
        do_access(0, 0, 0, 0, 16'h0010, 16'h0000);
        do_access(0, 0, 1, 1, 16'h0010, 16'h0000);
        do_access(0, 0, 0, 0, 16'h0013, 16'h0000);
        do_access(0, 2, 0, 0, 16'h0030, 16'hA5A5);
        do_access(0, 0, 0, 0, 16'h0030, 16'h0000);
        do_access(0, 1, 0, 0, 16'h0020, 16'h0000);

        // Store aborted by reset while busy
        @(posedge clk); #1;
        addr = 16'h0020; wdata = 16'h5555; be = 0; mw0 = 1'b1;
        @(posedge clk); #1;
        abort_run = 1'b1;
        rst_n = 1'b0;
        clear_req();
        #1;
        chk("abort rdata0", rd0, 0);
        chk("abort fault0", af0, 0);
        chk("abort stall0", stall0, 0);
        last_rd[0] = '0; last_rd[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_access(0, 0, 0, 0, 16'h0020, 16'h0000);

        do_access(1, 1, 0, 0, 16'h0200, 16'h1234);
        do_access(1, 0, 0, 0, 16'h0000, 16'h0000);

        for (int i = 0; i < 60; i++)
            do_access(int'($urandom % 2), int'($urandom % 3),
                      1'($urandom), 1'($urandom),
                      16'($urandom) & 16'hFE3F, 16'($urandom));

        check_branch();
        repeat (4) @(posedge clk);
        #1;
        chk("queue drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, default 16, data/address width in bits; legal values 16 or 32.
REQ-002 Parameter DEPTH, default 256, number of DATA_W words; power of 2, 16..4096.
REQ-003 Parameter WAIT_STATES, default 2, extra access cycles; legal 0..7.
REQ-004 Derived: BS = log2(DATA_W/8) byte-offset bits; AW = log2(DEPTH) word-index bits.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 address  input  DATA_W  byte address of access.
REQ-008 write_data  input  DATA_W  store data; byte stores use bits [7:0].
REQ-009 MemWrite  input  1  store request.
REQ-010 MemRead  input  1  load request.
REQ-011 byte_en  input  1  1 = byte access, 0 = full-word access.
REQ-012 sign_ext  input  1  1 = sign-extend byte loads, 0 = zero-extend.
REQ-013 Branch  input  1  branch instruction in this stage.
REQ-014 Zero  input  1  ALU zero flag.
REQ-015 branch_ne  input  1  1 = branch-if-not-equal, 0 = branch-if-equal.
REQ-016 read_data_mem  output  DATA_W  registered load result.
REQ-017 PCSrc_out  output  1  branch-taken select.
REQ-018 stall  output  1  pipeline hold; upstream SHALL keep all inputs stable while high.
REQ-019 align_fault  output  1  one-cycle pulse on misaligned word access.

Function
REQ-020 Word index = address[AW+BS-1:BS]; upper address bits ignored (wraps modulo DEPTH); byte lane = address[BS-1:0].
REQ-021 req = MemRead | MemWrite; both asserted SHALL be treated as a store, load ignored.
REQ-022 Misaligned = !byte_en & (address[BS-1:0] != 0); such a req in IDLE SHALL register align_fault=1 for exactly one cycle, no memory access, no stall, read_data_mem unchanged, FSM stays IDLE.
REQ-023 FSM states IDLE, BUSY, DONE; IDLE->BUSY on aligned req, capturing address, write_data, byte_en, sign_ext, type, and loading cnt=WAIT_STATES.
REQ-024 BUSY: cnt!=0 -> cnt-1, stay; cnt==0 -> DONE with access committed on that edge.
REQ-025 DONE -> IDLE unconditionally; no request is accepted in DONE.
REQ-026 stall = (IDLE & req & !misaligned) | BUSY, combinational; low in DONE.
REQ-027 stall is high for exactly WAIT_STATES+2 cycles per access; result visible in DONE cycle.
REQ-028 Input changes after IDLE->BUSY capture SHALL NOT affect the access in flight.
REQ-029 Word store writes all DATA_W bits; byte store writes only the addressed lane, other lanes preserved.
REQ-030 Word load returns full word; byte load returns addressed lane, extended per sign_ext to DATA_W.
REQ-031 read_data_mem updates only on load commit; holds value across stores, faults and idle cycles.
REQ-032 PCSrc_out = Branch & (Zero ^ branch_ne), combinational, independent of FSM and stall.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, cnt 0, read_data_mem 0, align_fault 0; stall then follows REQ-026.
REQ-034 Reset mid-access SHALL abort it; an uncommitted store SHALL NOT modify memory.
REQ-035 Memory array contents are not reset; benches SHALL write before reading.

Verification (DATA_W=16, DEPTH=256, WAIT_STATES=2 unless noted)
REQ-036 Word store 0xBEEF @0x0010, then word load @0x0010 -> stall high 4 cycles each, read_data_mem=0xBEEF in load DONE cycle.
REQ-037 After REQ-036: byte store 0x12 @0x0011, byte load @0x0011 sign_ext=0 -> 0x0012; word load @0x0010 -> 0x12EF; byte load @0x0010 sign_ext=1 -> 0xFFEF.
REQ-038 Word load @0x0013 -> align_fault one cycle, stall never high, read_data_mem unchanged.
REQ-039 Word store 0x5555 @0x0020 with rst_n pulsed low during BUSY -> outputs reset; later load @0x0020 does not return 0x5555 (prior value 0x0000 written).
REQ-040 WAIT_STATES=0: store 0x1234 @0x0200 then load @0x0000 -> stall 2 cycles, returns 0x1234 (wrap); Branch=1,Zero=0,branch_ne=1 -> PCSrc_out=1, Zero=1 -> 0.
